bcd_seg_scan_driver: RTL and testbench
======================================

Name: bcd_seg_scan_driver

Overview:
Consumes the three BCD digits (hundreds/tens/ones) produced by the binary-to-BCD converter and drives a 4-digit, common-anode, time-multiplexed 7-segment display. It latches new values through a load strobe and commits them only on frame boundaries, so the display never shows a mix of old and new digits. It also provides leading-zero blanking, invalid-digit flagging and a frame-done pulse. It sits between the converter and the board pins.

Parameters:
REFRESH_DIV, 100000, clk cycles per digit slot (100 MHz gives 1 kHz per slot); legal range >= 2

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
hundreds  input  4  BCD hundreds digit from converter
tens  input  4  BCD tens digit
ones  input  4  BCD ones digit
load  input  1  capture hundreds/tens/ones when high (level-sampled each cycle)
blank_lz  input  1  1 = blank leading zeros of hundreds/tens
an  output  4  anode enables, active-low; an[0] = ones position
seg  output  7  segments, active-low, {g,f,e,d,c,b,a}
dp  output  1  decimal point, active-low; held 1 (off)
frame_done  output  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset (sync, synchronous priority over everything):
  - an=4'b1111, seg=7'h7F, dp=1, frame_done=0.
  - Divider=0, slot index=0.
  - Pending and display registers cleared to 0; pending_valid=0; any pending load is discarded.
- Divider: counts 0..REFRESH_DIV-1. tick=1 in the cycle where count==REFRESH_DIV-1; count then wraps to 0.
- Slot index: 2-bit, advances on tick in the order 0,1,2,3,0. Slot 0=ones, 1=tens, 2=hundreds, 3=unused.
- Output timing:
  - an and seg are registered and update on the same edge as the index, reflecting the new index.
  - After reset, the outputs hold reset values until the first tick.
- Load path:
  - load=1 captures the inputs into the pending register and sets pending_valid.
  - A repeated load before commit overwrites; last write wins.
- Commit:
  - Happens on a tick where the index wraps 3->0 (the frame boundary) and pending_valid=1 (or load=1 that same cycle).
  - Source = load ? live inputs : pending register. pending_valid clears.
  - The new digits appear in slot 0 on that same edge.
- frame_done=1 for exactly the one cycle following each 3->0 wrap edge, whether or not a commit occurred.
- Slot drive:
  - Slots 0..2: an = one-hot-low of the index; seg = decode of the display digit.
  - Slot 3: an=4'b1111, seg=7'h7F.
- Decode (0-9):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any value 10-15 produces a dash, 0111111 (g only).
- Leading-zero blanking (blank_lz=1, evaluated combinationally against the display register at slot-update time):
  - Hundreds==0 blanks slot 2.
  - Hundreds==0 and tens==0 also blanks slot 1.
  - Ones is never blanked.
  - A blanked slot drives an=4'b1111, seg=7'h7F.
- Invalid digits (value >9) are never blanked; they always show the dash.
- dp is constant 1.

Test Plan:
- Reset: hold reset for 3 cycles, then release (REFRESH_DIV=4) -> an=1111, seg=7F, frame_done=0 until the first tick; the first tick gives an=1110 showing digit 0 (seg=1000000).
- Load 2,5,5 for one cycle, run 2 frames -> after the first frame_done: slot0 an=1110 seg=0010010; slot1 an=1101 seg=0010010; slot2 an=1011 seg=0100100; slot3 an=1111 seg=7F.
- Load 0,0,7 with blank_lz=1 -> slots 1 and 2 give an=1111; slot0 seg=1111000. With blank_lz=0 -> slots 1 and 2 show 1000000.
- Display 255, then load 1,2,3 while index=1 -> slots 1 and 2 keep showing 5 and 2 until the wrap; after frame_done, slots show 3,2,1.
- Load tens=4'hC, hundreds=0 with blank_lz=1 -> slot1 seg=0111111 (not blanked); slot2 blanked.
- Load asserted exactly on the 3->0 tick -> new ones digit visible in slot 0 on that edge. Reset asserted mid-slot-1 with a load pending -> the next cycle shows reset values, and the display register is 0 after restart.

Source files
------------

// File: rtl/bcd_seg_scan_if.sv
// ----------------------------------------------------------------------------
// bcd_seg_scan_if
// Bundle between the BCD source and the 4-digit scan driver.
//   hundreds/tens/ones : BCD digits from the converter
//   load               : capture strobe. Sampled as a level on every rising
//                        edge. There is no ready; the driver always accepts,
//                        and the last value loaded before a frame boundary
//                        is the one that gets displayed.
//   blank_lz           : 1 = blank leading zeros of hundreds/tens
//   an                 : anode enables, active-low, an[0] = ones position
//   seg                : segments {g,f,e,d,c,b,a}, active-low
//   dp                 : decimal point, active-low (always off)
//   frame_done         : one-cycle pulse after each frame boundary
// master = digit source / bench, slave = scan driver.
// ----------------------------------------------------------------------------
interface bcd_seg_scan_if;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       load;
    logic       blank_lz;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_done;

    modport master (
        output hundreds, tens, ones, load, blank_lz,
        input  an, seg, dp, frame_done
    );

    modport slave (
        input  hundreds, tens, ones, load, blank_lz,
        output an, seg, dp, frame_done
    );
endinterface

// File: rtl/bcd_seg_scan_driver.sv
// ----------------------------------------------------------------------------
// bcd_seg_scan_driver
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Digits are captured into a pending register by load and are committed to
// the display register only at the frame boundary (slot 3 -> slot 0), so a
// frame never mixes old and new digits.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : bcd_seg_scan_if.slave (digits, load, blank_lz, an, seg, dp,
//           frame_done)
// Parameter:
//   REFRESH_DIV : clk cycles per digit slot (>= 2)
// ----------------------------------------------------------------------------
module bcd_seg_scan_driver #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic           clk,
    input  logic           reset,
    bcd_seg_scan_if.slave  bus
);
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [CW-1:0] count;
    logic [1:0]    idx;
    // Low until the first tick after reset. That tick lights slot 0 without
    // advancing the index, so the scan starts at the ones position.
    logic          started;
    logic [3:0]    pend_h, pend_t, pend_o;
    logic          pending_valid;
    logic [3:0]    disp_h, disp_t, disp_o;
    logic [3:0]    an_r;
    logic [6:0]    seg_r;
    logic          frame_done_r;

    logic          tick, wrap, commit, blanked;
    logic [1:0]    idx_next;
    logic [3:0]    nh, nt, no, digit, an_next;
    logic [6:0]    seg_next;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b0111111;  // invalid digit: dash
        endcase
    endfunction

    assign tick = (count == CW'(REFRESH_DIV - 1));

    always_comb begin
        wrap     = tick && started && (idx == 2'd3);
        commit   = wrap && (pending_valid || bus.load);
        // Digits the display register will hold after this edge. Slot drive
        // uses these so a commit is visible in slot 0 on the same edge.
        nh       = disp_h;
        nt       = disp_t;
        no       = disp_o;
        if (commit) begin
            nh = bus.load ? bus.hundreds : pend_h;
            nt = bus.load ? bus.tens     : pend_t;
            no = bus.load ? bus.ones     : pend_o;
        end
        idx_next = started ? idx + 2'd1 : idx;
        case (idx_next)
            2'd0:    digit = no;
            2'd1:    digit = nt;
            default: digit = nh;
        endcase
        // Only zero digits are blanked, so invalid digits always show a dash.
        blanked  = bus.blank_lz &&
                   (((idx_next == 2'd2) && (nh == 4'd0)) ||
                    ((idx_next == 2'd1) && (nh == 4'd0) && (nt == 4'd0)));
        an_next  = 4'b1111;
        seg_next = 7'h7F;
        if ((idx_next != 2'd3) && !blanked) begin
            an_next  = ~(4'b0001 << idx_next);
            seg_next = decode(digit);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count         <= '0;
            idx           <= 2'd0;
            started       <= 1'b0;
            pend_h        <= 4'd0;
            pend_t        <= 4'd0;
            pend_o        <= 4'd0;
            pending_valid <= 1'b0;
            disp_h        <= 4'd0;
            disp_t        <= 4'd0;
            disp_o        <= 4'd0;
            an_r          <= 4'b1111;
            seg_r         <= 7'h7F;
            frame_done_r  <= 1'b0;
        end else begin
            frame_done_r <= wrap;
            if (tick) begin
                count   <= '0;
                idx     <= idx_next;
                started <= 1'b1;
                an_r    <= an_next;
                seg_r   <= seg_next;
            end else begin
                count <= count + CW'(1);
            end
            if (commit) begin
                disp_h        <= nh;
                disp_t        <= nt;
                disp_o        <= no;
                pending_valid <= 1'b0;
            end else if (bus.load) begin
                pend_h        <= bus.hundreds;
                pend_t        <= bus.tens;
                pend_o        <= bus.ones;
                pending_valid <= 1'b1;
            end
        end
    end

    assign bus.an         = an_r;
    assign bus.seg        = seg_r;
    assign bus.dp         = 1'b1;
    assign bus.frame_done = frame_done_r;
endmodule

// File: tb/tb_bcd_seg_scan_driver.sv
// ----------------------------------------------------------------------------
// tb_bcd_seg_scan_driver
// Directed scenarios followed by random traffic. A cycle-level reference
// model (plain integers and a digit-to-segment table) predicts an, seg, dp
// and frame_done for every cycle; directed steps also check fixed constants.
// ----------------------------------------------------------------------------
module tb_bcd_seg_scan_driver;
    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bcd_seg_scan_if bus ();

    bcd_seg_scan_driver #(.REFRESH_DIV(DIV)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // reference model state (digit arrays: 0 = ones, 1 = tens, 2 = hundreds)
    int         m_cnt     = 0;
    int         m_idx     = 0;
    bit         m_started = 0;
    bit         m_pv      = 0;
    bit         m_tick    = 0;
    bit         m_fd      = 0;
    int         m_pend[3] = '{0, 0, 0};
    int         m_disp[3] = '{0, 0, 0};
    logic [3:0] m_an      = 4'b1111;
    logic [6:0] m_seg     = 7'h7F;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance the model by one clock using the inputs applied right now.
    task automatic model_step();
        int in_d[3];
        bit blank;
        in_d[0] = int'(bus.ones);
        in_d[1] = int'(bus.tens);
        in_d[2] = int'(bus.hundreds);
        if (rst) begin
            m_cnt = 0; m_idx = 0; m_started = 0; m_pv = 0;
            m_tick = 0; m_fd = 0;
            m_pend = '{0, 0, 0};
            m_disp = '{0, 0, 0};
            m_an = 4'b1111; m_seg = 7'h7F;
        end else begin
            m_tick = (m_cnt == DIV - 1);
            m_cnt  = m_tick ? 0 : m_cnt + 1;
            m_fd   = m_tick && m_started && (m_idx == 3);
            if (m_fd && (bus.load || m_pv)) begin
                if (bus.load) m_disp = in_d;
                else          m_disp = m_pend;
                m_pv = 0;
            end else if (bus.load) begin
                m_pend = in_d;
                m_pv   = 1;
            end
            if (m_tick) begin
                if (m_started) m_idx = (m_idx + 1) % 4;
                m_started = 1;
                blank = bus.blank_lz &&
                        ((m_idx == 2 && m_disp[2] == 0) ||
                         (m_idx == 1 && m_disp[2] == 0 && m_disp[1] == 0));
                if (m_idx == 3 || blank) begin
                    m_an  = 4'b1111;
                    m_seg = 7'h7F;
                end else begin
                    m_an  = 4'b1111 & ~(4'b0001 << m_idx);
                    m_seg = seg_of(m_disp[m_idx]);
                end
            end
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #2;
        chk("an", bus.an, m_an);
        chk("seg", bus.seg, m_seg);
        chk("frame_done", bus.frame_done, m_fd);
        chk("dp", bus.dp, 1);
    endtask

    task automatic next_tick();
        int n = 0;
        do begin cyc(); n++; end while (!m_tick && n < 3 * DIV);
        if (!m_tick) chk("tick_timeout", 0, 1);
    endtask

    task automatic to_frame();
        int n = 0;
        do begin cyc(); n++; end while (!m_fd && n < 6 * DIV);
        if (!m_fd) chk("frame_timeout", 0, 1);
    endtask

    task automatic set_in(input int h, input int t, input int o);
        bus.hundreds = 4'(h);
        bus.tens     = 4'(t);
        bus.ones     = 4'(o);
    endtask

    task automatic pulse_load(input int h, input int t, input int o);
        set_in(h, t, o);
        bus.load = 1'b1;
        cyc();
        bus.load = 1'b0;
    endtask

    initial begin
        int n;
        bus.load = 1'b0;
        bus.blank_lz = 1'b0;
        set_in(0, 0, 0);

        // reset held 3 cycles, outputs dark until the first tick
        rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        chk("post_rst_an", bus.an, 4'b1111);
        chk("post_rst_seg", bus.seg, 7'h7F);
        next_tick();
        chk("first_tick_an", bus.an, 4'b1110);
        chk("first_tick_seg", bus.seg, 7'b1000000);

        // load 255
        pulse_load(2, 5, 5);
        to_frame();
        chk("255_s0_an", bus.an, 4'b1110);
        chk("255_s0_seg", bus.seg, 7'b0010010);
        next_tick();
        chk("255_s1_an", bus.an, 4'b1101);
        chk("255_s1_seg", bus.seg, 7'b0010010);
        next_tick();
        chk("255_s2_an", bus.an, 4'b1011);
        chk("255_s2_seg", bus.seg, 7'b0100100);
        next_tick();
        chk("255_s3_an", bus.an, 4'b1111);
        chk("255_s3_seg", bus.seg, 7'h7F);

        // 007 with and without leading-zero blanking
        bus.blank_lz = 1'b1;
        pulse_load(0, 0, 7);
        to_frame();
        chk("007_s0_seg", bus.seg, 7'b1111000);
        next_tick();
        chk("007_s1_blank", bus.an, 4'b1111);
        next_tick();
        chk("007_s2_blank", bus.an, 4'b1111);
        bus.blank_lz = 1'b0;
        next_tick();
        next_tick();
        next_tick();
        chk("007_s1_an", bus.an, 4'b1101);
        chk("007_s1_seg", bus.seg, 7'b1000000);
        next_tick();
        chk("007_s2_seg", bus.seg, 7'b1000000);

        // load mid-frame is held until the wrap
        pulse_load(2, 5, 5);
        to_frame();
        next_tick();
        pulse_load(1, 2, 3);
        chk("hold_s1_seg", bus.seg, 7'b0010010);
        next_tick();
        chk("hold_s2_seg", bus.seg, 7'b0100100);
        to_frame();
        chk("123_s0_seg", bus.seg, 7'b0110000);
        next_tick();
        chk("123_s1_seg", bus.seg, 7'b0100100);
        next_tick();
        chk("123_s2_seg", bus.seg, 7'b1111001);

        // invalid tens is never blanked
        bus.blank_lz = 1'b1;
        pulse_load(0, 12, 4);
        to_frame();
        next_tick();
        chk("inv_s1_an", bus.an, 4'b1101);
        chk("inv_s1_seg", bus.seg, 7'b0111111);
        next_tick();
        chk("inv_s2_blank", bus.an, 4'b1111);
        bus.blank_lz = 1'b0;

        // load exactly on the wrap tick
        n = 0;
        while (!(m_started && m_idx == 3 && m_cnt == DIV - 1) && n < 8 * DIV) begin
            cyc();
            n++;
        end
        set_in(9, 9, 8);
        bus.load = 1'b1;
        cyc();
        bus.load = 1'b0;
        chk("wrap_load_fd", bus.frame_done, 1);
        chk("wrap_load_seg", bus.seg, 7'b0000000);

        // reset mid-slot-1 with a load pending
        next_tick();
        pulse_load(4, 4, 4);
        rst = 1'b1;
        cyc();
        chk("mid_rst_an", bus.an, 4'b1111);
        chk("mid_rst_seg", bus.seg, 7'h7F);
        chk("mid_rst_fd", bus.frame_done, 0);
        rst = 1'b0;
        next_tick();
        chk("restart_s0_seg", bus.seg, 7'b1000000);
        to_frame();
        chk("restart_frame_s0_seg", bus.seg, 7'b1000000);
        next_tick();
        chk("restart_frame_s1_seg", bus.seg, 7'b1000000);

        // random traffic against the model
        for (int i = 0; i < 800; i++) begin
            rst      = ($urandom_range(0, 199) == 0);
            bus.load = ($urandom_range(0, 5) == 0);
            set_in(($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 15),
                   ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 15),
                   $urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) bus.blank_lz = ~bus.blank_lz;
            cyc();
        end
        rst = 1'b0;
        bus.load = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
